image_buffer_arbiter: RTL and testbench

IMAGE_BUFFER_ARBITER -- requirements
Module: image_buffer_arbiter

---
 rtl/bnn_pkg.sv | 21 ++
 rtl/image_buffer_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_image_buffer_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_pkg.sv
// Shared constants and types for the BNN image path: image size, buffer
// address width and the image buffer arbiter state encoding.
package bnn_pkg;

    localparam int unsigned IMG_BYTES = 98;
    localparam int unsigned ADDR_W    = 7;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_WRITE,
        ARB_READ,
        ARB_READ_WAIT,
        ARB_CLEAR
    } arb_state_e;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } grant_e;

endpackage

// File: rtl/image_buffer_arbiter.sv
// Arbitrates controller writes and BNN reads onto one external single-port RAM,
// tracks the image fill level and sweeps the RAM to zero on a clear request.
module image_buffer_arbiter #(
    parameter int unsigned IMG_BYTES = bnn_pkg::IMG_BYTES,
    parameter int unsigned ADDR_W    = bnn_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    output logic              wr_ready,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ready,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic              buffer_full,
    output logic              buffer_empty,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    import bnn_pkg::*;

    localparam int unsigned       CNT_W     = $clog2(IMG_BYTES + 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(IMG_BYTES);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic              pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0] pend_wr_addr_q, pend_wr_addr_d;
    logic [7:0]        pend_wr_data_q, pend_wr_data_d;
    logic              pend_rd_q, pend_rd_d;
    logic [ADDR_W-1:0] pend_rd_addr_q, pend_rd_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] sweep_q, sweep_d;
    logic              clear_q;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              wr_ack_q, wr_ack_d;
    logic              rd_valid_q, rd_valid_d;
    logic [7:0]        rd_data_q, rd_data_d;

    logic clear_rise, abort, clearing;
    logic grant_wr, grant_rd, wr_in_range;

    assign clear_rise = clear && !clear_q;
    // A clear edge during the sweep itself is ignored rather than restarting it.
    assign abort      = clear_rise && (state_q != ARB_CLEAR);
    assign clearing   = (state_q == ARB_CLEAR) || abort;

    assign buffer_full  = (count_q == FULL_CNT);
    assign buffer_empty = (count_q == '0) && (state_q != ARB_CLEAR);
    assign wr_ready     = !pend_wr_q && !buffer_full && !clearing;
    assign rd_ready     = !pend_rd_q && !clearing;

    // Round-robin only matters when both are pending; last grant flips on contention.
    assign grant_wr    = pend_wr_q && (!pend_rd_q || (last_grant_q == GRANT_READ));
    assign grant_rd    = pend_rd_q && !grant_wr;
    assign wr_in_range = 32'(pend_wr_addr_q) < IMG_BYTES;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        pend_wr_d      = pend_wr_q;
        pend_wr_addr_d = pend_wr_addr_q;
        pend_wr_data_d = pend_wr_data_q;
        pend_rd_d      = pend_rd_q;
        pend_rd_addr_d = pend_rd_addr_q;
        count_d        = count_q;
        sweep_d        = sweep_q;
        mem_en_d       = 1'b0;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        wr_ack_d       = 1'b0;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;

        if (wr_req && wr_ready) begin
            pend_wr_d      = 1'b1;
            pend_wr_addr_d = wr_addr;
            pend_wr_data_d = wr_data;
        end
        if (rd_req && rd_ready) begin
            pend_rd_d      = 1'b1;
            pend_rd_addr_d = rd_addr;
        end

        if (abort) begin
            state_d     = ARB_CLEAR;
            pend_wr_d   = 1'b0;
            pend_rd_d   = 1'b0;
            sweep_d     = '0;
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = '0;
            mem_wdata_d = 8'h00;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pend_wr_q && pend_rd_q) begin
                        last_grant_d = grant_wr ? GRANT_WRITE : GRANT_READ;
                    end
                    if (grant_wr) begin
                        state_d     = ARB_WRITE;
                        pend_wr_d   = 1'b0;
                        wr_ack_d    = 1'b1;
                        mem_addr_d  = pend_wr_addr_q;
                        mem_wdata_d = pend_wr_data_q;
                        // Out-of-range writes are acknowledged but never reach the RAM.
                        if (wr_in_range) begin
                            mem_en_d = 1'b1;
                            mem_we_d = 1'b1;
                            if (count_q != FULL_CNT) begin
                                count_d = count_q + 1'b1;
                            end
                        end
                    end else if (grant_rd) begin
                        state_d    = ARB_READ;
                        mem_en_d   = 1'b1;
                        mem_addr_d = pend_rd_addr_q;
                    end
                end
                ARB_WRITE: state_d = ARB_IDLE;
                ARB_READ:  state_d = ARB_READ_WAIT;
                ARB_READ_WAIT: begin
                    rd_data_d  = mem_rdata;
                    rd_valid_d = 1'b1;
                    pend_rd_d  = 1'b0;
                    state_d    = ARB_IDLE;
                end
                ARB_CLEAR: begin
                    if (sweep_q == LAST_ADDR) begin
                        state_d = ARB_IDLE;
                        count_d = '0;
                    end else begin
                        sweep_d     = sweep_q + 1'b1;
                        mem_en_d    = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = sweep_q + 1'b1;
                        mem_wdata_d = 8'h00;
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ARB_IDLE;
            last_grant_q   <= GRANT_READ;
            pend_wr_q      <= 1'b0;
            pend_wr_addr_q <= '0;
            pend_wr_data_q <= 8'h00;
            pend_rd_q      <= 1'b0;
            pend_rd_addr_q <= '0;
            count_q        <= '0;
            sweep_q        <= '0;
            clear_q        <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 8'h00;
            wr_ack_q       <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= 8'h00;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            pend_wr_q      <= pend_wr_d;
            pend_wr_addr_q <= pend_wr_addr_d;
            pend_wr_data_q <= pend_wr_data_d;
            pend_rd_q      <= pend_rd_d;
            pend_rd_addr_q <= pend_rd_addr_d;
            count_q        <= count_d;
            sweep_q        <= sweep_d;
            clear_q        <= clear;
            mem_en_q       <= mem_en_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            wr_ack_q       <= wr_ack_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wr_ack    = wr_ack_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_image_buffer_arbiter.sv
// Directed bench for image_buffer_arbiter with a behavioural single-port RAM.
module tb_image_buffer_arbiter;

    logic       clk, rst_n, clear;
    logic       wr_req, wr_ready, wr_ack;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_req, rd_ready, rd_valid;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       buffer_full, buffer_empty;
    logic       mem_en, mem_we;
    logic [6:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;

    logic [7:0] ram [0:127];
    int errors = 0;
    int checks = 0;

    image_buffer_arbiter #(.IMG_BYTES(98), .ADDR_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid),
        .buffer_full(buffer_full), .buffer_empty(buffer_empty),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) cyc();
        checks++; if ({wr_ack, rd_valid, mem_en, mem_we} !== 4'b0000) begin
            errors++; $display("FAIL reset_pulses: got %b expected 0000", {wr_ack, rd_valid, mem_en, mem_we});
        end
        checks++; if ({mem_addr, mem_wdata, rd_data} !== 23'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, rd_data});
        end
        checks++; if ({buffer_empty, buffer_full, wr_ready, rd_ready} !== 4'b1011) begin
            errors++; $display("FAIL reset_flags: got %b expected 1011", {buffer_empty, buffer_full, wr_ready, rd_ready});
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_write();
        wr_req = 1'b1; wr_addr = 7'd3; wr_data = 8'hA5;
        cyc();
        wr_req = 1'b0;
        checks++; if (wr_ack !== 1'b0) begin
            errors++; $display("FAIL write_early_ack: got %b expected 0", wr_ack);
        end
        cyc();
        checks++; if ({wr_ack, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 7'd3, 8'hA5}) begin
            errors++; $display("FAIL write_commit: got %h expected %h",
                {wr_ack, mem_en, mem_we, mem_addr, mem_wdata}, {3'b111, 7'd3, 8'hA5});
        end
        checks++; if (buffer_empty !== 1'b0) begin
            errors++; $display("FAIL write_empty_fall: got %b expected 0", buffer_empty);
        end
        cyc();
        checks++; if ({wr_ack, mem_en} !== 2'b00) begin
            errors++; $display("FAIL write_pulse_end: got %b expected 00", {wr_ack, mem_en});
        end
    endtask

    task automatic test_read();
        rd_req = 1'b1; rd_addr = 7'd3;
        cyc();
        rd_req = 1'b0;
        cyc(); cyc();
        checks++; if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL read_early_valid: got %b expected 0", rd_valid);
        end
        cyc();
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL read_data: got %h expected 1a5", {rd_valid, rd_data});
        end
        cyc();
        checks++; if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL read_pulse_end: got %b expected 0", rd_valid);
        end
    endtask

    task automatic test_out_of_range();
        wr_req = 1'b1; wr_addr = 7'd100; wr_data = 8'h5A;
        cyc();
        wr_req = 1'b0;
        cyc();
        checks++; if ({wr_ack, mem_we} !== 2'b10) begin
            errors++; $display("FAIL oor_write: got ack/we %b expected 10", {wr_ack, mem_we});
        end
        cyc();
    endtask

    task automatic test_arbitration();
        wr_req = 1'b1; wr_addr = 7'd10; wr_data = 8'h3C;
        rd_req = 1'b1; rd_addr = 7'd3;
        cyc();
        wr_req = 1'b0; rd_req = 1'b0;
        cyc();
        checks++; if ({wr_ack, mem_we, mem_addr} !== {2'b11, 7'd10}) begin
            errors++; $display("FAIL arb1_write_first: got %h expected %h", {wr_ack, mem_we, mem_addr}, {2'b11, 7'd10});
        end
        cyc(); cyc();
        checks++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 7'd3}) begin
            errors++; $display("FAIL arb1_read_second: got %h expected %h", {mem_en, mem_we, mem_addr}, {2'b10, 7'd3});
        end
        cyc(); cyc();
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'hA5}) begin
            errors++; $display("FAIL arb1_read_data: got %h expected 1a5", {rd_valid, rd_data});
        end
        wr_req = 1'b1; wr_addr = 7'd11; wr_data = 8'h77;
        rd_req = 1'b1; rd_addr = 7'd10;
        cyc();
        wr_req = 1'b0; rd_req = 1'b0;
        cyc();
        checks++; if ({wr_ack, mem_en, mem_we, mem_addr} !== {3'b010, 7'd10}) begin
            errors++; $display("FAIL arb2_read_first: got %h expected %h", {wr_ack, mem_en, mem_we, mem_addr}, {3'b010, 7'd10});
        end
        cyc(); cyc();
        checks++; if ({rd_valid, rd_data} !== {1'b1, 8'h3C}) begin
            errors++; $display("FAIL arb2_read_data: got %h expected 13c", {rd_valid, rd_data});
        end
        cyc();
        checks++; if ({wr_ack, mem_we, mem_addr, mem_wdata} !== {2'b11, 7'd11, 8'h77}) begin
            errors++; $display("FAIL arb2_write_second: got %h expected %h",
                {wr_ack, mem_we, mem_addr, mem_wdata}, {2'b11, 7'd11, 8'h77});
        end
        cyc();
    endtask

    // Three bytes are already counted, so 95 more reach the 98-byte limit.
    task automatic test_fill();
        int acks = 0;
        int seen = 0;
        for (int i = 0; i < 95; i++) begin
            wr_req = 1'b1; wr_addr = 7'(i); wr_data = 8'(i + 1);
            cyc();
            wr_req = 1'b0;
            cyc();
            if (wr_ack === 1'b1) acks++;
            if (i == 93) begin
                checks++; if (buffer_full !== 1'b0) begin
                    errors++; $display("FAIL fill_early_full: got %b expected 0", buffer_full);
                end
            end
        end
        checks++; if (acks != 95) begin
            errors++; $display("FAIL fill_acks: got %0d expected 95", acks);
        end
        checks++; if ({buffer_full, wr_ready} !== 2'b10) begin
            errors++; $display("FAIL fill_full: got full/ready %b expected 10", {buffer_full, wr_ready});
        end
        wr_req = 1'b1; wr_addr = 7'd96; wr_data = 8'hEE;
        cyc();
        wr_req = 1'b0;
        repeat (4) begin
            cyc();
            if (wr_ack === 1'b1 || mem_we === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin
            errors++; $display("FAIL fill_drop_99th: got %0d write events expected 0", seen);
        end
    endtask

    task automatic test_read_when_full();
        rd_req = 1'b1; rd_addr = 7'd5;
        cyc();
        rd_req = 1'b0;
        cyc(); cyc(); cyc();
        checks++; if ({rd_valid, rd_data, buffer_full} !== {1'b1, 8'h06, 1'b1}) begin
            errors++; $display("FAIL full_read: got %h expected %h", {rd_valid, rd_data, buffer_full}, {1'b1, 8'h06, 1'b1});
        end
        cyc();
    endtask

    // A second clear edge mid-sweep must neither restart nor extend the sweep.
    task automatic test_clear_pending_read();
        int nwr = 0;
        int sum = 0;
        int rv  = 0;
        rd_req = 1'b1; rd_addr = 7'd5;
        cyc();
        rd_req = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0;
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 15'h0}) begin
            errors++; $display("FAIL clear_start: got %h expected %h", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 15'h0});
        end
        if (mem_we === 1'b1) nwr++;
        for (int j = 1; j < 98; j++) begin
            if (j == 40) clear = 1'b1;
            if (j == 42) clear = 1'b0;
            cyc();
            if (mem_en === 1'b1 && mem_we === 1'b1 && mem_wdata === 8'h00) begin
                nwr++;
                sum += int'(mem_addr);
            end
            if (rd_valid === 1'b1) rv++;
        end
        checks++; if (nwr != 98 || sum != 4753) begin
            errors++; $display("FAIL clear_sweep: got %0d writes sum %0d expected 98 sum 4753", nwr, sum);
        end
        checks++; if ({buffer_empty, mem_addr} !== {1'b0, 7'd97}) begin
            errors++; $display("FAIL clear_last_write: got %h expected %h", {buffer_empty, mem_addr}, {1'b0, 7'd97});
        end
        cyc();
        if (rd_valid === 1'b1) rv++;
        checks++; if ({buffer_empty, buffer_full, mem_en, wr_ready} !== 4'b1001) begin
            errors++; $display("FAIL clear_done: got %b expected 1001", {buffer_empty, buffer_full, mem_en, wr_ready});
        end
        checks++; if (rv != 0) begin
            errors++; $display("FAIL clear_no_rd_valid: got %0d expected 0", rv);
        end
        checks++; if (ram[5] !== 8'h00 || ram[97] !== 8'h00) begin
            errors++; $display("FAIL clear_ram_zero: got %h %h expected 00 00", ram[5], ram[97]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int seen = 0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        repeat (5) cyc();
        checks++; if (mem_we !== 1'b1) begin
            errors++; $display("FAIL midsweep_active: got %b expected 1", mem_we);
        end
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_en, mem_we, buffer_empty} !== 3'b001) begin
            errors++; $display("FAIL midsweep_reset: got %b expected 001", {mem_en, mem_we, buffer_empty});
        end
        cyc();
        rst_n = 1'b1;
        repeat (6) begin
            cyc();
            if (mem_we === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin
            errors++; $display("FAIL midsweep_abandon: got %0d writes expected 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_out_of_range();
        test_arbitration();
        test_fill();
        test_read_when_full();
        test_clear_pending_read();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
